// File: rtl/apb_fsm_controller_pkg.sv
// Shared definitions for the APB-side bridge sequencer: widths, FSM states,
// slave address windows and the one-hot select decoder.
package apb_fsm_controller_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NSLV   = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_e;

  // What the output registers do on the coming edge; chosen alongside the next state.
  typedef enum logic [2:0] {
    ACT_PARK    = 3'd0,
    ACT_READ    = 3'd1,
    ACT_WRITE_A = 3'd2,
    ACT_WRITE_B = 3'd3,
    ACT_ENABLE  = 3'd4,
    ACT_RESET   = 3'd5
  } act_e;

  localparam logic [ADDR_W-1:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [ADDR_W-1:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [ADDR_W-1:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [ADDR_W-1:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [ADDR_W-1:0] SLV2_LIMIT = 32'h8BFF_FFFF;

  function automatic logic [NSLV-1:0] sel_decode(input logic [ADDR_W-1:0] addr);
    logic [NSLV-1:0] sel;
    if ((addr >= SLV0_BASE) && (addr <= SLV0_LIMIT)) begin
      sel = 3'b001;
    end else if ((addr >= SLV1_BASE) && (addr <= SLV1_LIMIT)) begin
      sel = 3'b010;
    end else if ((addr >= SLV2_BASE) && (addr <= SLV2_LIMIT)) begin
      sel = 3'b100;
    end else begin
      sel = 3'b000;
    end
    return sel;
  endfunction

endpackage

// File: rtl/apb_fsm_controller_if.sv
// Bus bundle between the AHB slave interface, the APB sequencer and the APB
// slaves. The sequencer uses the master view.
interface apb_fsm_controller_if;
  import apb_fsm_controller_pkg::*;

  logic              valid;
  logic              Hwrite;
  logic              Hwritereg;
  logic [ADDR_W-1:0] Haddr;
  logic [ADDR_W-1:0] Haddr1;
  logic [ADDR_W-1:0] Haddr2;
  logic [DATA_W-1:0] Hwdata;
  logic [DATA_W-1:0] Hwdata1;

  logic [NSLV-1:0]   Pselx;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Pwrite;
  logic              Penable;
  logic              Hreadyout;

  modport master (
    input  valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1,
    output Pselx, Paddr, Pwdata, Pwrite, Penable, Hreadyout
  );

  modport slave (
    output valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1,
    input  Pselx, Paddr, Pwdata, Pwrite, Penable, Hreadyout
  );

endinterface

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB-to-APB bridge: SETUP->ENABLE phasing with
// pipelined back-to-back writes; Hreadyout stretches AHB during APB SETUP.
module apb_fsm_controller
  import apb_fsm_controller_pkg::*;
(
  input logic                 Hclk,
  input logic                 Hresetn,
  apb_fsm_controller_if.master bus
);

  state_e            state_q, state_d;
  act_e              act_s;
  logic [NSLV-1:0]   pselx_q, pselx_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              penable_q, penable_d;
  logic              hreadyout_q, hreadyout_d;

  // Next state and output-register action.
  always_comb begin
    state_d = state_q;
    act_s   = ACT_PARK;
    case (state_q)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (!bus.valid) begin
          state_d = ST_IDLE;
          act_s   = ACT_PARK;
        end else if (bus.Hwrite) begin
          state_d = ST_WWAIT;
          act_s   = ACT_PARK;
        end else begin
          state_d = ST_READ;
          act_s   = ACT_READ;
        end
      end
      ST_WWAIT: begin
        act_s = ACT_WRITE_A;
        if (bus.valid) begin
          state_d = ST_WRITEP;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        state_d = ST_RENABLE;
        act_s   = ACT_ENABLE;
      end
      ST_WRITE: begin
        act_s = ACT_ENABLE;
        if (bus.valid) begin
          state_d = ST_WENABLEP;
        end else begin
          state_d = ST_WENABLE;
        end
      end
      ST_WRITEP: begin
        state_d = ST_WENABLEP;
        act_s   = ACT_ENABLE;
      end
      ST_WENABLEP: begin
        // A pipelined write's address is two cycles old by the time its data lands.
        if (!bus.Hwritereg) begin
          state_d = ST_READ;
          act_s   = ACT_READ;
        end else if (bus.valid) begin
          state_d = ST_WRITEP;
          act_s   = ACT_WRITE_B;
        end else begin
          state_d = ST_WRITE;
          act_s   = ACT_WRITE_B;
        end
      end
      default: begin
        state_d = ST_IDLE;
        act_s   = ACT_RESET;
      end
    endcase
  end

  // Output register next values for the chosen action.
  always_comb begin
    pselx_d     = pselx_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    penable_d   = penable_q;
    hreadyout_d = hreadyout_q;
    case (act_s)
      ACT_PARK: begin
        pselx_d     = {NSLV{1'b0}};
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
      end
      ACT_READ: begin
        paddr_d     = bus.Haddr;
        pselx_d     = sel_decode(bus.Haddr);
        pwrite_d    = 1'b0;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
      end
      ACT_WRITE_A: begin
        paddr_d     = bus.Haddr1;
        pwdata_d    = bus.Hwdata;
        pselx_d     = sel_decode(bus.Haddr1);
        pwrite_d    = 1'b1;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
      end
      ACT_WRITE_B: begin
        paddr_d     = bus.Haddr2;
        pwdata_d    = bus.Hwdata1;
        pselx_d     = sel_decode(bus.Haddr2);
        pwrite_d    = 1'b1;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
      end
      ACT_ENABLE: begin
        penable_d   = 1'b1;
        hreadyout_d = 1'b1;
      end
      default: begin
        pselx_d     = {NSLV{1'b0}};
        paddr_d     = {ADDR_W{1'b0}};
        pwdata_d    = {DATA_W{1'b0}};
        pwrite_d    = 1'b0;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= ST_IDLE;
      pselx_q     <= {NSLV{1'b0}};
      paddr_q     <= {ADDR_W{1'b0}};
      pwdata_q    <= {DATA_W{1'b0}};
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pselx_q     <= pselx_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      penable_q   <= penable_d;
      hreadyout_q <= hreadyout_d;
    end
  end

  assign bus.Pselx     = pselx_q;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Penable   = penable_q;
  assign bus.Hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: directed bridge scenarios plus random traffic,
// with expected outputs queued by a reference model and popped by a monitor.
module tb_apb_fsm_controller;
  import apb_fsm_controller_pkg::*;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pwrite;
    logic        penable;
    logic        ready;
  } obs_t;

  localparam int PH_IDLE = 0, PH_WWAIT = 1, PH_READ = 2, PH_WRITE = 3,
                 PH_WRITEP = 4, PH_RENABLE = 5, PH_WENABLE = 6, PH_WENABLEP = 7;

  logic Hclk = 1'b0;
  logic Hresetn;
  apb_fsm_controller_if bus();

  apb_fsm_controller dut (.Hclk(Hclk), .Hresetn(Hresetn), .bus(bus));

  always #5 Hclk = ~Hclk;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_phase;
  obs_t m_o;
  obs_t reset_obs;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endfunction

  // Slave windows are 64 MiB each starting at 0x8000_0000.
  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    logic [31:0] idx;
    if (a < 32'h8000_0000) return 3'b000;
    idx = (a - 32'h8000_0000) / 32'h0400_0000;
    if (idx < 32'd3) return 3'(32'd1 << idx);
    return 3'b000;
  endfunction

  task automatic m_park();
    m_o.sel = 3'b000; m_o.penable = 1'b0; m_o.ready = 1'b1;
  endtask

  task automatic m_setup(input logic [31:0] a, input logic w, input logic [31:0] d);
    m_o.addr = a; m_o.sel = ref_sel(a); m_o.pwrite = w;
    if (w) m_o.wdata = d;
    m_o.penable = 1'b0; m_o.ready = 1'b0;
  endtask

  task automatic m_step();
    case (m_phase)
      PH_WWAIT: begin
        m_setup(bus.Haddr1, 1'b1, bus.Hwdata);
        m_phase = bus.valid ? PH_WRITEP : PH_WRITE;
      end
      PH_READ: begin
        m_o.penable = 1'b1; m_o.ready = 1'b1; m_phase = PH_RENABLE;
      end
      PH_WRITE, PH_WRITEP: begin
        m_o.penable = 1'b1; m_o.ready = 1'b1;
        m_phase = (m_phase == PH_WRITEP || bus.valid) ? PH_WENABLEP : PH_WENABLE;
      end
      PH_WENABLEP: begin
        if (!bus.Hwritereg) begin
          m_setup(bus.Haddr, 1'b0, 32'h0); m_phase = PH_READ;
        end else begin
          m_setup(bus.Haddr2, 1'b1, bus.Hwdata1);
          m_phase = bus.valid ? PH_WRITEP : PH_WRITE;
        end
      end
      default: begin
        if (!bus.valid) begin
          m_park(); m_phase = PH_IDLE;
        end else if (bus.Hwrite) begin
          m_park(); m_phase = PH_WWAIT;
        end else begin
          m_setup(bus.Haddr, 1'b0, 32'h0); m_phase = PH_READ;
        end
      end
    endcase
  endtask

  // One bus cycle: shift the AHB pipeline, apply new inputs, queue the expected outputs.
  task automatic drive(input logic rst_n, input logic v, input logic hw,
                       input logic [31:0] ha, input logic [31:0] hd);
    @(negedge Hclk);
    bus.Haddr2    = bus.Haddr1;
    bus.Haddr1    = bus.Haddr;
    bus.Hwritereg = bus.Hwrite;
    bus.Hwdata1   = bus.Hwdata;
    bus.valid     = v;
    bus.Hwrite    = hw;
    bus.Haddr     = ha;
    bus.Hwdata    = hd;
    Hresetn       = rst_n;
    if (!rst_n) begin
      #1;
      chk("rst_sel", {29'd0, bus.Pselx}, 32'h0);
      chk("rst_addr", bus.Paddr, 32'h0);
      chk("rst_wdata", bus.Pwdata, 32'h0);
      chk("rst_ctl", {29'd0, bus.Pwrite, bus.Penable, bus.Hreadyout}, 32'h1);
      m_phase = PH_IDLE;
      m_o     = reset_obs;
    end else begin
      m_step();
    end
    exp_q.push_back(m_o);
  endtask

  task automatic after_edge();
    @(posedge Hclk);
    #2;
  endtask

  // Monitor: one queued expectation per clock edge.
  initial begin
    obs_t e, g;
    forever begin
      @(posedge Hclk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = {bus.Pselx, bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Penable, bus.Hreadyout};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t: got sel=%b addr=%h wdata=%h pw=%b pen=%b rdy=%b want sel=%b addr=%h wdata=%h pw=%b pen=%b rdy=%b",
                   $time, g.sel, g.addr, g.wdata, g.pwrite, g.penable, g.ready,
                   e.sel, e.addr, e.wdata, e.pwrite, e.penable, e.ready);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] r;
    reset_obs     = '{sel: 3'b000, addr: 32'h0, wdata: 32'h0, pwrite: 1'b0, penable: 1'b0, ready: 1'b1};
    m_o           = reset_obs;
    m_phase       = PH_IDLE;
    Hresetn       = 1'b0;
    bus.valid     = 1'b0; bus.Hwrite = 1'b0; bus.Hwritereg = 1'b0;
    bus.Haddr     = 32'h0; bus.Haddr1 = 32'h0; bus.Haddr2 = 32'h0;
    bus.Hwdata    = 32'h0; bus.Hwdata1 = 32'h0;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Single read.
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
    after_edge();
    chk("rd_setup", {bus.Pselx, bus.Pwrite, bus.Penable, bus.Hreadyout}, 32'h8);
    chk("rd_addr", bus.Paddr, 32'h8000_0010);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    after_edge();
    chk("rd_enable", {bus.Pselx, bus.Penable, bus.Hreadyout}, 32'h7);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    after_edge();
    chk("rd_idle", {bus.Pselx, bus.Penable, bus.Hreadyout}, 32'h1);

    // Single write.
    drive(1'b1, 1'b1, 1'b1, 32'h8400_0004, 32'h0);
    after_edge();
    chk("wr_wwait_rdy", {31'd0, bus.Hreadyout}, 32'h1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hA5A5_A5A5);
    after_edge();
    chk("wr_addr", bus.Paddr, 32'h8400_0004);
    chk("wr_data", bus.Pwdata, 32'hA5A5_A5A5);
    chk("wr_setup", {bus.Pselx, bus.Pwrite, bus.Penable, bus.Hreadyout}, 32'h14);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    after_edge();
    chk("wr_enable", {31'd0, bus.Penable}, 32'h1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Back-to-back writes.
    drive(1'b1, 1'b1, 1'b1, 32'h8800_0000, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h8800_0004, 32'h1);
    after_edge();
    chk("b2b_first", bus.Paddr, 32'h8800_0000);
    drive(1'b1, 1'b0, 1'b1, 32'h8800_0004, 32'h2);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h2);
    after_edge();
    chk("b2b_second_addr", bus.Paddr, 32'h8800_0004);
    chk("b2b_second_data", bus.Pwdata, 32'h2);
    chk("b2b_sel", {29'd0, bus.Pselx}, 32'h4);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Write followed by pipelined read.
    drive(1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0008, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 1'b0, 32'h8000_0008, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h8000_0008, 32'h0);
    after_edge();
    chk("wr_rd_addr", bus.Paddr, 32'h8000_0008);
    chk("wr_rd_dir", {31'd0, bus.Pwrite}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Out-of-window address without valid.
    drive(1'b1, 1'b0, 1'b1, 32'h9000_0000, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h9000_0000, 32'h0);
    after_edge();
    chk("oow_idle", {bus.Pselx, bus.Penable, bus.Hreadyout}, 32'h1);

    // Reset in the middle of a write.
    drive(1'b1, 1'b1, 1'b1, 32'h8000_0020, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Random traffic, including unmapped addresses and occasional resets.
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      case (r[2:0])
        3'd0:    ra = 32'h9000_0000 + {16'd0, r[31:16]};
        3'd1:    ra = 32'h0000_1000 + {16'd0, r[31:16]};
        default: ra = 32'h8000_0000 + {4'd0, 2'(r[3:0] % 4'd3), r[31:6]};
      endcase
      drive(($urandom_range(0, 99) != 0), r[4] | r[5], r[6], ra, $urandom);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    after_edge();
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
